// File: rtl/complex_accumulator.sv
// complex_accumulator
//   Sums LEN consecutive accepted complex products (packed {imag, real},
//   each WIDTH-bit two's complement) into ACC_W-bit real/imag accumulators
//   and presents each frame sum on a valid/ready output.
//
//   Optional feature: define COMPLEX_ACCUMULATOR_SAT_EN to make each part's
//   add saturate at the signed ACC_W bounds and report any saturation in the
//   frame on ovf. Undefined: wrap arithmetic, ovf tied to 0.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   clr       in   synchronous frame abort (priority over all but rst_n)
//   in_valid  in   product word valid
//   in_ready  out  product can be accepted this cycle
//   in_data   in   [WIDTH-1:0] real, [2*WIDTH-1:WIDTH] imag
//   out_valid out  frame sum valid
//   out_ready in   downstream accepts the sum
//   out_data  out  [ACC_W-1:0] real sum, [2*ACC_W-1:ACC_W] imag sum
//   ovf       out  saturation seen in the presented frame
module complex_accumulator #(
  parameter int WIDTH = 32,
  parameter int ACC_W = 40,
  parameter int LEN   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*ACC_W-1:0]   out_data,
  output logic                 ovf
);

  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(LEN - 1);
  localparam logic [0:0] ST_ACC  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]         state_r;
  logic [CW-1:0]      count_r;
  logic [ACC_W-1:0]   acc_re_r;
  logic [ACC_W-1:0]   acc_im_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [2*ACC_W-1:0] out_data_r;
  logic [ACC_W-1:0]   re_sum_s;
  logic [ACC_W-1:0]   im_sum_s;
  logic               accept_s;
  logic               last_beat_s;
  logic               handshake_s;

  // Sign-extend one WIDTH-bit part to ACC_W bits.
  function automatic logic [ACC_W-1:0] sext(input logic [WIDTH-1:0] p);
    sext = ACC_W'($signed(p));
  endfunction

`ifdef COMPLEX_ACCUMULATOR_SAT_EN
  // Saturating add; sum is formed one bit wider so overflow is the
  // disagreement of the top two bits.
  function automatic logic [ACC_W-1:0] part_add(input logic [ACC_W-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [ACC_W-1:0] b_ext;
    logic [ACC_W:0]   sum;
    b_ext = sext(b);
    sum   = {a[ACC_W-1], a} + {b_ext[ACC_W-1], b_ext};
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      if (sum[ACC_W]) begin
        part_add = {1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        part_add = {1'b0, {(ACC_W-1){1'b1}}};
      end
    end else begin
      part_add = sum[ACC_W-1:0];
    end
  endfunction

  // True when the part add would leave the signed ACC_W range.
  function automatic logic part_sat(input logic [ACC_W-1:0] a,
                                    input logic [WIDTH-1:0] b);
    logic [ACC_W-1:0] b_ext;
    logic [ACC_W:0]   sum;
    b_ext    = sext(b);
    sum      = {a[ACC_W-1], a} + {b_ext[ACC_W-1], b_ext};
    part_sat = (sum[ACC_W] != sum[ACC_W-1]);
  endfunction
`else
  // Plain modulo-2^ACC_W add.
  function automatic logic [ACC_W-1:0] part_add(input logic [ACC_W-1:0] a,
                                                input logic [WIDTH-1:0] b);
    part_add = a + sext(b);
  endfunction
`endif

  assign re_sum_s    = part_add(acc_re_r, in_data[WIDTH-1:0]);
  assign im_sum_s    = part_add(acc_im_r, in_data[2*WIDTH-1:WIDTH]);
  assign accept_s    = in_valid && in_ready_r;
  assign last_beat_s = accept_s && (count_r == LAST_CNT);
  assign handshake_s = out_valid_r && out_ready;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

  // Frame FSM: accumulate in ACC, present sum in HOLD until handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_ACC;
      count_r     <= {CW{1'b0}};
      acc_re_r    <= {ACC_W{1'b0}};
      acc_im_r    <= {ACC_W{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_data_r  <= {(2*ACC_W){1'b0}};
    end else if (clr) begin
      state_r     <= ST_ACC;
      count_r     <= {CW{1'b0}};
      acc_re_r    <= {ACC_W{1'b0}};
      acc_im_r    <= {ACC_W{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_ACC: begin
          if (last_beat_s) begin
            out_data_r  <= {im_sum_s, re_sum_s};
            acc_re_r    <= {ACC_W{1'b0}};
            acc_im_r    <= {ACC_W{1'b0}};
            count_r     <= {CW{1'b0}};
            state_r     <= ST_HOLD;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b1;
          end else if (accept_s) begin
            acc_re_r <= re_sum_s;
            acc_im_r <= im_sum_s;
            count_r  <= count_r + {{(CW-1){1'b0}}, 1'b1};
          end else begin
            count_r <= count_r;
          end
        end
        ST_HOLD: begin
          // Handshake cycle still refuses input: one bubble per frame.
          if (handshake_s) begin
            state_r     <= ST_ACC;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
          end else begin
            state_r <= ST_HOLD;
          end
        end
        default: begin
          state_r     <= ST_ACC;
          count_r     <= {CW{1'b0}};
          acc_re_r    <= {ACC_W{1'b0}};
          acc_im_r    <= {ACC_W{1'b0}};
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef COMPLEX_ACCUMULATOR_SAT_EN
  logic sticky_r;
  logic ovf_r;
  logic sat_beat_s;

  assign sat_beat_s = part_sat(acc_re_r, in_data[WIDTH-1:0]) |
                      part_sat(acc_im_r, in_data[2*WIDTH-1:WIDTH]);
  assign ovf = ovf_r;

  // Sticky saturation tracking; handed to ovf alongside the frame sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_r <= 1'b0;
      ovf_r    <= 1'b0;
    end else if (clr) begin
      sticky_r <= 1'b0;
      ovf_r    <= 1'b0;
    end else if (last_beat_s) begin
      ovf_r    <= sticky_r | sat_beat_s;
      sticky_r <= 1'b0;
    end else if (accept_s) begin
      sticky_r <= sticky_r | sat_beat_s;
    end else if (handshake_s) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_complex_accumulator.sv
module tb_complex_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic [63:0] in_data;
  logic        out_ready;

  logic        in_ready, out_valid, ovf;
  logic [79:0] out_data;
  logic        in_ready_n, out_valid_n, ovf_n;
  logic [63:0] out_data_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  complex_accumulator #(.WIDTH(32), .ACC_W(40), .LEN(16)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .ovf(ovf)
  );

  // Narrow accumulator (ACC_W == WIDTH) shares the stimulus.
  complex_accumulator #(.WIDTH(32), .ACC_W(32), .LEN(16)) dut_n (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
    .in_ready(in_ready_n), .in_data(in_data), .out_valid(out_valid_n),
    .out_ready(out_ready), .out_data(out_data_n), .ovf(ovf_n)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [31:0] re, input logic [31:0] im,
                            input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        tick();
      end
      in_valid = 1'b1;
      in_data  = {im, re};
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL frame_in_ready beat %0d: got %b want 1", i, in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = 64'h0; out_ready = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 80'h0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d=%h o=%b want 0/0/0", out_valid, out_data, ovf);
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    send_frame(32'h0000_0001, 32'hFFFF_FFFF, 16, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== {40'hFF_FFFF_FFF0, 40'h00_0000_0010}) begin
      errors++;
      $display("FAIL basic_sum: got v=%b d=%h want 1 fffffffff00000000010", out_valid, out_data);
    end
    checks++;
    if (in_ready !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL basic_hold_flags: got rdy=%b ovf=%b want 0/0", in_ready, ovf);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_after_hs: got v=%b rdy=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_stall;
    out_ready = 1'b0;
    send_frame(32'h0000_0001, 32'hFFFF_FFFF, 16, 1'b1);
    // Offer junk during HOLD; it must never be accepted.
    in_valid = 1'b1;
    in_data  = {32'h0, 32'd100};
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          out_data !== {40'hFF_FFFF_FFF0, 40'h00_0000_0010}) begin
        errors++;
        $display("FAIL stall_hold cyc %0d: got v=%b rdy=%b d=%h", i, out_valid, in_ready, out_data);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: got v=%b rdy=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    send_frame(32'd2, 32'd0, 16, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== {40'h0, 40'h00_0000_0020}) begin
      errors++;
      $display("FAIL b2b_frame_a: got v=%b d=%h want 1 %h", out_valid, out_data, {40'h0, 40'h20});
    end
    tick();
    send_frame(32'hFFFF_FFFD, 32'd0, 16, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== {40'h0, 40'hFF_FFFF_FFD0}) begin
      errors++;
      $display("FAIL b2b_frame_b: got v=%b d=%h want 1 %h", out_valid, out_data, {40'h0, 40'hFF_FFFF_FFD0});
    end
    tick();
  endtask

  task automatic test_clr;
    out_ready = 1'b1;
    send_frame(32'd1, 32'd0, 7, 1'b0);
    clr = 1'b1; in_valid = 1'b1; in_data = {32'd0, 32'd50};
    tick();
    clr = 1'b0; in_valid = 1'b0;
    send_frame(32'd1, 32'd0, 15, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clr_early_output: got v=%b want 0", out_valid);
    end
    send_frame(32'd1, 32'd0, 1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== {40'h0, 40'h00_0000_0010}) begin
      errors++;
      $display("FAIL clr_mid_frame: got v=%b d=%h want 1 %h", out_valid, out_data, {40'h0, 40'h10});
    end
    tick();
    out_ready = 1'b0;
    send_frame(32'd1, 32'd0, 16, 1'b0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL clr_in_hold: got v=%b rdy=%b ovf=%b want 0/1/0", out_valid, in_ready, ovf);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_sat;
    logic [63:0] exp_n;
    logic        exp_ovf;
`ifdef COMPLEX_ACCUMULATOR_SAT_EN
    exp_n = {32'h0, 32'h7FFF_FFFF}; exp_ovf = 1'b1;
`else
    exp_n = {32'h0, 32'hFFFF_FFF0}; exp_ovf = 1'b0;
`endif
    out_ready = 1'b0;
    send_frame(32'h7FFF_FFFF, 32'd0, 16, 1'b0);
    checks++;
    if (out_valid_n !== 1'b1 || out_data_n !== exp_n || ovf_n !== exp_ovf) begin
      errors++;
      $display("FAIL sat_narrow: got v=%b d=%h ovf=%b want 1 %h %b", out_valid_n, out_data_n, ovf_n, exp_n, exp_ovf);
    end
    checks++;
    if (out_data !== {40'h0, 40'h07_FFFF_FFF0} || ovf !== 1'b0) begin
      errors++;
      $display("FAIL sat_wide: got d=%h ovf=%b want %h 0", out_data, ovf, {40'h0, 40'h7_FFFF_FFF0});
    end
    tick();
    checks++;
    if (ovf_n !== exp_ovf) begin
      errors++;
      $display("FAIL sat_ovf_hold: got %b want %b", ovf_n, exp_ovf);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (ovf_n !== 1'b0 || out_valid_n !== 1'b0) begin
      errors++;
      $display("FAIL sat_ovf_clear: got ovf=%b v=%b want 0/0", ovf_n, out_valid_n);
    end
    send_frame(32'd1, 32'd0, 16, 1'b0);
    checks++;
    if (out_data_n !== {32'h0, 32'h10} || ovf_n !== 1'b0) begin
      errors++;
      $display("FAIL sat_next_frame: got d=%h ovf=%b want %h 0", out_data_n, ovf_n, {32'h0, 32'h10});
    end
    tick();
  endtask

  task automatic test_rst_mid;
    out_ready = 1'b1;
    send_frame(32'd5, 32'd0, 10, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 80'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got v=%b d=%h want 0 0", out_valid, out_data);
    end
    tick();
    rst_n = 1'b1;
    tick();
    send_frame(32'd5, 32'd0, 16, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== {40'h0, 40'h00_0000_0050}) begin
      errors++;
      $display("FAIL rst_mid_sum: got v=%b d=%h want 1 %h", out_valid, out_data, {40'h0, 40'h50});
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_clr();
    test_sat();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
